// File: rtl/count_rmw_scheduler.sv
// Sequencer for the counting SRAM: arbitrates hit increments against host readouts
// and runs a full-array clear sweep, all over a four-phase request/done handshake.
module count_rmw_scheduler #(
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 12,
  parameter int MEM_SIZE  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_start,
  output logic                 clr_busy,
  input  logic                 hit_valid,
  input  logic [ADDR_BITS-1:0] hit_addr,
  output logic                 hit_ready,
  input  logic                 rd_valid,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic                 rd_ready,
  output logic                 rd_data_valid,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 sat_flag,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_din,
  input  logic [DATA_BITS-1:0] mem_dout,
  output logic                 mem_read,
  input  logic                 mem_read_done,
  output logic                 mem_write,
  input  logic                 mem_write_done
);

  typedef enum logic [2:0] {
    IDLE, CLR_WR, CLR_REL, RD_REQ, RD_REL, INC_WR, WR_REL, RESP
  } state_t;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(MEM_SIZE - 1);

  state_t               state;
  logic                 prefer_rd;
  logic                 op_inc;
  logic [ADDR_BITS-1:0] clr_cnt;
  logic [DATA_BITS-1:0] rd_buf;
  logic [DATA_BITS:0]   inc_sum;
  logic                 grant_ok;

  assign inc_sum = {1'b0, rd_buf} + (DATA_BITS+1)'(1);

  // Grants also wait for both dones low, so a reset mid-handshake cannot start a
  // new request while the SRAM is still finishing the abandoned one.
  assign grant_ok  = (state == IDLE) && !clr_start && !rst &&
                     !mem_read_done && !mem_write_done;
  assign rd_ready  = grant_ok && rd_valid  && (!hit_valid || prefer_rd);
  assign hit_ready = grant_ok && hit_valid && (!rd_valid  || !prefer_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      prefer_rd     <= 1'b1;
      op_inc        <= 1'b0;
      clr_cnt       <= '0;
      rd_buf        <= '0;
      clr_busy      <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
      sat_flag      <= 1'b0;
      mem_addr      <= '0;
      mem_din       <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
    end else begin
      rd_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start && !mem_read_done && !mem_write_done) begin
            clr_cnt   <= '0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_write <= 1'b1;
            clr_busy  <= 1'b1;
            sat_flag  <= 1'b0;
            state     <= CLR_WR;
          end else if (rd_ready) begin
            mem_addr  <= rd_addr;
            mem_read  <= 1'b1;
            op_inc    <= 1'b0;
            prefer_rd <= 1'b0;
            state     <= RD_REQ;
          end else if (hit_ready) begin
            mem_addr  <= hit_addr;
            mem_read  <= 1'b1;
            op_inc    <= 1'b1;
            prefer_rd <= 1'b1;
            state     <= RD_REQ;
          end
        end
        CLR_WR: if (mem_write_done) begin
          mem_write <= 1'b0;
          state     <= CLR_REL;
        end
        CLR_REL: if (!mem_write_done) begin
          if (clr_cnt == LAST_ADDR) begin
            clr_busy <= 1'b0;
            state    <= IDLE;
          end else begin
            clr_cnt   <= clr_cnt + 1'b1;
            mem_addr  <= clr_cnt + 1'b1;
            mem_write <= 1'b1;
            state     <= CLR_WR;
          end
        end
        RD_REQ: if (mem_read_done) begin
          rd_buf   <= mem_dout;
          mem_read <= 1'b0;
          state    <= RD_REL;
        end
        RD_REL: if (!mem_read_done) begin
          if (op_inc) begin
            // Saturated counters are rewritten unchanged so every hit costs one write.
            mem_din   <= inc_sum[DATA_BITS] ? rd_buf : inc_sum[DATA_BITS-1:0];
            if (inc_sum[DATA_BITS]) sat_flag <= 1'b1;
            mem_write <= 1'b1;
            state     <= INC_WR;
          end else begin
            state <= RESP;
          end
        end
        INC_WR: if (mem_write_done) begin
          mem_write <= 1'b0;
          state     <= WR_REL;
        end
        WR_REL: if (!mem_write_done) state <= IDLE;
        RESP: begin
          rd_data       <= rd_buf;
          rd_data_valid <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_rmw_scheduler.sv
// Bench for count_rmw_scheduler: behavioural counter array + SRAM model with
// random wait states, directed scenarios, then a randomized hit/readout mix.
module tb_count_rmw_scheduler;
  localparam int AW = 6;
  localparam int DW = 12;
  localparam int MS = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_start, clr_busy;
  logic          hit_valid, hit_ready, rd_valid, rd_ready;
  logic [AW-1:0] hit_addr, rd_addr, mem_addr;
  logic          rd_data_valid, sat_flag;
  logic [DW-1:0] rd_data, mem_din, mem_dout;
  logic          mem_read, mem_read_done, mem_write, mem_write_done;

  count_rmw_scheduler #(.ADDR_BITS(AW), .DATA_BITS(DW), .MEM_SIZE(MS)) dut (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(clr_busy),
    .hit_valid(hit_valid), .hit_addr(hit_addr), .hit_ready(hit_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .sat_flag(sat_flag),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_read(mem_read), .mem_read_done(mem_read_done),
    .mem_write(mem_write), .mem_write_done(mem_write_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] sram    [MS];
  logic [DW-1:0] ref_mem [MS];
  logic [DW-1:0] exp_q   [$];
  bit            ref_sat = 1'b0;
  int            max_wait = 0;
  int            wcnt = 0;
  int            wr_count = 0, wr_nonzero = 0;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_val = '0;
  logic [36:0]   outs;

  assign outs = {clr_busy, hit_ready, rd_ready, rd_data_valid, rd_data, sat_flag,
                 mem_addr, mem_din, mem_read, mem_write};

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SRAM model: done follows the request after 0..max_wait extra cycles each way.
  initial begin
    mem_read_done  = 1'b0;
    mem_write_done = 1'b0;
    mem_dout       = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mem_read_done  <= 1'b0;
        mem_write_done <= 1'b0;
        wcnt = 0;
      end else begin
        if (pl_en) sram[pl_addr] = pl_val;
        if ((mem_read || mem_write) && !mem_read_done && !mem_write_done) begin
          if (wcnt > 0) wcnt--;
          else begin
            if (mem_read) begin
              mem_read_done <= 1'b1;
              mem_dout      <= sram[mem_addr];
            end else begin
              mem_write_done <= 1'b1;
              sram[mem_addr] = mem_din;
              wr_count++;
              if (mem_din != 0) wr_nonzero++;
            end
            wcnt = $urandom_range(max_wait, 0);
          end
        end else if (!mem_read && !mem_write && (mem_read_done || mem_write_done)) begin
          if (wcnt > 0) wcnt--;
          else begin
            mem_read_done  <= 1'b0;
            mem_write_done <= 1'b0;
            wcnt = $urandom_range(max_wait, 0);
          end
        end
      end
    end
  end

  // Compare process: protocol rules every cycle, readout data against the model.
  initial begin
    bit p_rd, p_wr, p_rdn, p_wdn;
    logic [DW-1:0] e;
    p_rd = 0; p_wr = 0; p_rdn = 0; p_wdn = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_rd = 0; p_wr = 0; p_rdn = 0; p_wdn = 0;
      end else begin
        check(!(mem_read && mem_write), "mem_overlap", {mem_read, mem_write}, 0);
        check(!(hit_ready && rd_ready), "ready_excl", {hit_ready, rd_ready}, 0);
        check(!((p_rd && !mem_read && !p_rdn) || (p_wr && !mem_write && !p_wdn)),
              "req_dropped_early", {mem_read, mem_write}, {p_rd, p_wr});
        check(!(((mem_read && !p_rd) || (mem_write && !p_wr)) && (p_rdn || p_wdn)),
              "req_before_done_low", {mem_read, mem_write}, 0);
        if (rd_data_valid) begin
          if (exp_q.size() == 0) check(0, "rd_unexpected", rd_data, 0);
          else begin
            e = exp_q.pop_front();
            check(rd_data == e, "rd_data", rd_data, e);
            check(sat_flag == ref_sat, "sat_flag", sat_flag, ref_sat);
          end
        end
        if (rd_valid && rd_ready) exp_q.push_back(ref_mem[rd_addr]);
        if (hit_valid && hit_ready) begin
          if (ref_mem[hit_addr] == {DW{1'b1}}) ref_sat = 1'b1;
          else ref_mem[hit_addr] = ref_mem[hit_addr] + 1'b1;
        end
        p_rd = mem_read; p_wr = mem_write; p_rdn = mem_read_done; p_wdn = mem_write_done;
      end
    end
  end

  task automatic send(input bit is_rd, input int a);
    bit acc;
    int n;
    acc = 0; n = 0;
    if (is_rd) begin rd_addr = AW'(a); rd_valid = 1'b1; end
    else begin hit_addr = AW'(a); hit_valid = 1'b1; end
    while (!acc && n < 3000) begin
      @(negedge clk);
      acc = is_rd ? rd_ready : hit_ready;
      @(posedge clk); #1;
      n++;
    end
    if (is_rd) rd_valid = 1'b0; else hit_valid = 1'b0;
    if (!acc) check(0, "accept_timeout", n, 0);
  endtask

  task automatic wait_rdv(output int lat);
    lat = -1;
    do begin @(negedge clk); lat++; end while (!rd_data_valid && lat < 3000);
    if (!rd_data_valid) check(0, "rdv_timeout", lat, 0);
  endtask

  task automatic read_lit(input int a, input int exp, input string name);
    int lat;
    send(1'b1, a);
    wait_rdv(lat);
    check(rd_data == DW'(exp), name, rd_data, exp);
    @(posedge clk); #1;
  endtask

  task automatic wait_quiet();
    int q, n;
    q = 0; n = 0;
    while (q < 3 && n < 5000) begin
      @(negedge clk);
      if (!mem_read && !mem_write && !mem_read_done && !mem_write_done) q++; else q = 0;
      n++;
    end
    if (q < 3) check(0, "quiet_timeout", n, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    int n;
    wait_quiet();
    wr_count = 0; wr_nonzero = 0;
    clr_start = 1'b1;
    for (int i = 0; i < MS; i++) ref_mem[i] = '0;
    ref_sat = 1'b0;
    @(posedge clk); #1;
    clr_start = 1'b0;
    @(negedge clk);
    check(clr_busy == 1'b1, "clr_busy_rise", clr_busy, 1);
    n = 0;
    while (clr_busy && n < 20000) begin @(negedge clk); n++; end
    check(!clr_busy, "clr_timeout", clr_busy, 0);
    check(wr_count == MS, "clr_write_count", wr_count, MS);
    check(wr_nonzero == 0, "clr_nonzero_writes", wr_nonzero, 0);
    @(posedge clk); #1;
  endtask

  task automatic preload(input int a, input int v);
    wait_quiet();
    pl_addr = AW'(a); pl_val = DW'(v); pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[a] = DW'(v);
  endtask

  initial begin
    int lat, n, g, nd, hits, rds;
    int grant[4];
    logic [DW-1:0] data[2];
    logic [DW-1:0] save;
    bit ah, ar;

    rst = 1'b0; clr_start = 1'b0;
    hit_valid = 1'b1; rd_valid = 1'b1; hit_addr = '0; rd_addr = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    check(outs == 0, "reset_outputs", outs, 0);
    hit_valid = 1'b0; rd_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // Clear, then read back corners
    do_clear();
    read_lit(0, 0, "clr_rd0");
    read_lit(31, 0, "clr_rd31");
    read_lit(63, 0, "clr_rd63");
    check(sat_flag == 1'b0, "clr_sat", sat_flag, 0);

    // Increment sequence
    repeat (3) send(1'b0, 5);
    send(1'b0, 6);
    read_lit(5, 3, "inc_rd5");
    read_lit(6, 1, "inc_rd6");

    // Zero-wait latencies
    send(1'b1, 6);
    wait_rdv(lat);
    check(lat == 5, "rd_latency", lat, 5);
    @(posedge clk); #1;
    send(1'b0, 7);
    rd_addr = 7; rd_valid = 1'b1;
    lat = -1;
    do begin @(negedge clk); lat++; end while (!rd_ready && lat < 100);
    check(lat == 8, "inc_latency", lat, 8);
    @(posedge clk); #1;
    rd_valid = 1'b0;
    wait_rdv(lat);
    check(rd_data == 1, "inc_rd7", rd_data, 1);
    @(posedge clk); #1;

    // Saturation
    preload(10, 4094);
    send(1'b0, 10); wait_quiet();
    check(sat_flag == 1'b0, "sat_after_hit1", sat_flag, 0);
    send(1'b0, 10); wait_quiet();
    check(sat_flag == 1'b1, "sat_after_hit2", sat_flag, 1);
    send(1'b0, 10); wait_quiet();
    check(sat_flag == 1'b1, "sat_after_hit3", sat_flag, 1);
    read_lit(10, 4095, "sat_rd10");
    do_clear();
    check(sat_flag == 1'b0, "sat_cleared", sat_flag, 0);

    // Reset while the increment write is outstanding
    wait_quiet();
    save = ref_mem[20];
    hit_addr = 20; hit_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_write && n < 200);
    check(mem_write == 1'b1, "rst_wait_write", mem_write, 1);
    #2 rst = 1'b1;
    #1 check(outs == 0, "reset_async_outputs", outs, 0);
    ref_mem[20] = save;
    ref_sat = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check(hit_ready == 1'b1, "hit_ready_after_rst", hit_ready, 1);
    @(posedge clk); #1 hit_valid = 1'b0;
    wait_quiet();

    // Arbitration with both requesters held on addr 2
    rd_addr = 2; hit_addr = 2; rd_valid = 1'b1; hit_valid = 1'b1;
    g = 0; nd = 0; n = 0;
    while ((g < 4 || nd < 2) && n < 2000) begin
      @(negedge clk);
      if (rd_data_valid && nd < 2) begin data[nd] = rd_data; nd++; end
      if (g < 4 && (rd_ready || hit_ready)) begin grant[g] = rd_ready ? 1 : 0; g++; end
      @(posedge clk); #1;
      if (g == 4) begin rd_valid = 1'b0; hit_valid = 1'b0; end
      n++;
    end
    rd_valid = 1'b0; hit_valid = 1'b0;
    check(g == 4 && nd == 2, "arb_timeout", g, 4);
    for (int i = 0; i < 4; i++) check(grant[i] == ((i % 2 == 0) ? 1 : 0), "arb_grant", grant[i], (i % 2 == 0) ? 1 : 0);
    check(data[0] == 0, "arb_rd_first", data[0], 0);
    check(data[1] == 1, "arb_rd_second", data[1], 1);
    wait_quiet();

    // Slow SRAM, randomized mix
    max_wait = 5;
    do_clear();
    hits = 0; rds = 0; n = 0;
    while ((hits < 120 || rds < 120 || hit_valid || rd_valid) && n < 40000) begin
      @(negedge clk);
      ah = hit_valid && hit_ready;
      ar = rd_valid && rd_ready;
      @(posedge clk); #1;
      if (ah) hit_valid = 1'b0;
      if (ar) rd_valid = 1'b0;
      if (!hit_valid && hits < 120 && $urandom_range(3, 0) == 0) begin
        hit_addr = AW'($urandom_range(1, 0) ? $urandom_range(3, 0) : $urandom_range(MS-1, 0));
        hit_valid = 1'b1; hits++;
      end
      if (!rd_valid && rds < 120 && $urandom_range(3, 0) == 0) begin
        rd_addr = AW'($urandom_range(1, 0) ? $urandom_range(3, 0) : $urandom_range(MS-1, 0));
        rd_valid = 1'b1; rds++;
      end
      n++;
    end
    check(!hit_valid && !rd_valid, "random_timeout", n, 0);
    hit_valid = 1'b0; rd_valid = 1'b0;
    wait_quiet();
    repeat (3) @(negedge clk);
    check(exp_q.size() == 0, "reads_outstanding", exp_q.size(), 0);
    for (int i = 0; i < MS; i++) check(sram[i] == ref_mem[i], "sram_contents", sram[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_rmw_scheduler.md
Name: count_rmw_scheduler

Overview:
- Sequences the 64x12 counting SRAM for a single client port. Arbitrates hit-increment requests against host readout requests, and runs a full-array clear sweep.
- Increments are performed as read-modify-write with saturation.
- Sits between the hit/host front end and the SRAM handshake pins (read/read_done, write/write_done). It replaces ad-hoc mode sequencing with a request/ready interface.

Parameters:
ADDR_BITS, 6, SRAM address width
DATA_BITS, 12, counter/data width
MEM_SIZE, 64, number of counters; clear sweep covers 0..MEM_SIZE-1

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset, asynchronous, active-high
clr_start  in  1  single-cycle pulse; starts clear sweep
clr_busy  out  1  high while clear sweep runs
hit_valid  in  1  increment request
hit_addr  in  ADDR_BITS  counter to increment
hit_ready  out  1  hit accepted when hit_valid&hit_ready
rd_valid  in  1  readout request
rd_addr  in  ADDR_BITS  counter to read
rd_ready  out  1  readout accepted when rd_valid&rd_ready
rd_data_valid  out  1  one-cycle pulse, rd_data valid
rd_data  out  DATA_BITS  readout value, held until next pulse
sat_flag  out  1  sticky: some increment hit saturation
mem_addr  out  ADDR_BITS  SRAM address
mem_din  out  DATA_BITS  SRAM write data
mem_dout  in  DATA_BITS  SRAM read data
mem_read  out  1  SRAM read request, active high
mem_read_done  in  1  SRAM read acknowledge
mem_write  out  1  SRAM write request, active high
mem_write_done  in  1  SRAM write acknowledge

Behaviour:
- Reset values: all outputs 0. FSM is in IDLE, the internal arbitration pointer is set to favour readout, and sat_flag is cleared.
- The reset is asynchronous. Reset mid-operation drops mem_read and mem_write immediately and abandons the operation. A partial clear is not resumed.
- SRAM handshake is four-phase:
  - Drive mem_addr and mem_din stable, then raise the request.
  - Hold the request until its done signal is sampled 1, then drop the request on the next edge.
  - No new request is issued until done is sampled 0.
  - mem_dout is captured on the edge where mem_read_done is sampled 1.
  - mem_read and mem_write are never high together.
- FSM states are IDLE, CLR_WR, CLR_REL, RD_REQ, RD_REL, INC_WR, WR_REL, RESP.
- Priority in IDLE:
  1. clr_start wins over everything.
  2. If both rd_valid and hit_valid are high, they alternate round-robin. The pointer flips after each grant.
  3. A single pending request is granted directly.
- hit_ready and rd_ready are high only in IDLE with clr_start low. They are combinational from state, the pointer and the valids. At most one of them is high in any cycle. The request address is registered on acceptance.
- Clear sweep:
  - IDLE goes to CLR_WR with counter=0.
  - Each address is written 0 (CLR_WR then CLR_REL). The counter increments after the release, i.e. after write_done is sampled 0.
  - The FSM returns to IDLE after address MEM_SIZE-1.
  - clr_busy is high from the cycle after clr_start until the IDLE return.
  - sat_flag is cleared on clr_start acceptance.
  - clr_start pulses outside IDLE are ignored.
- Readout: IDLE, then RD_REQ, RD_REL, RESP, then IDLE. In RESP, rd_data is loaded and rd_data_valid pulses for exactly one cycle.
- Increment:
  - The FSM goes IDLE, RD_REQ, RD_REL, INC_WR, WR_REL, IDLE.
  - The write value is the read value + 1, computed in DATA_BITS+1 bits.
  - If the read value is 2^DATA_BITS-1, the write value stays 2^DATA_BITS-1 and sat_flag sets. The write is still performed.
- Latency with zero-wait SRAM (done rises the cycle after the request):
  - Readout: acceptance to rd_data_valid is 5 cycles.
  - Increment: acceptance to IDLE is 8 cycles.
- Requests asserted during a busy period are not lost upstream: ready stays low and the requester holds valid.

Test Plan:
- Clear then read: pulse clr_start, wait for clr_busy to fall, then read addresses 0, 31 and 63. Required: exactly 64 writes of 0 occur, every rd_data=0, and sat_flag=0.
- Increment sequence: after clear, send 3 hits to addr 5 and 1 hit to addr 6, then read both. Required: rd_data=3 and rd_data=1.
- Saturation: preload addr 10 with 4094 through the SRAM model, then send 3 hits. Required: reading addr 10 returns 4095; sat_flag rises on the 2nd hit and stays high until the next clr_start.
- Arbitration: hold hit_valid (addr 2) and rd_valid (addr 2) continuously for 4 grants. Required: grants alternate rd, hit, rd, hit, and successive reads return 0 then 1.
- Handshake with a slow SRAM model inserting 0–5 random wait cycles on done rise and fall. Required: no overlapping mem_read/mem_write, requests held until done, and results identical to zero-wait.
- Reset mid-increment: assert rst while mem_write is high. Required: all outputs 0 within the same cycle, FSM returns to IDLE, and hit_ready is high after rst deasserts.
